glitch_delay_filter: RTL and testbench
======================================

# glitch_delay_filter

Parametrised multi-channel synchronous delay/filter block that generalises our continuous-time inertial/transport delay study into clocked RTL. Each channel produces two outputs: a transport-delayed copy that preserves every pulse, and an inertially filtered copy that drops pulses shorter than a programmable width. Dropped pulses are flagged per channel and counted. The block sits between asynchronous-ish control inputs (already synchronised) and downstream logic that needs debounced levels.

## Interface
- CH, 2, number of independent channels (≥1)
- DELAY, 4, transport delay in clk cycles (≥1)
- FILT, 3, minimum stable width in cycles for the inertial path (≥1)
- CNTW, 8, width of the drop counter
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  clock enable; low freezes all state
- din  input  CH  channel inputs, already synchronous to clk
- cnt_clr  input  1  synchronous clear of drop_cnt
- dout_trans  output  CH  transport-delayed din
- dout_inert  output  CH  inertially filtered din
- drop  output  CH  one-cycle pulse per channel when a short pulse is rejected
- drop_cnt  output  CNTW  saturating total of rejected pulses, all channels

## Operation
- Reset (rst=1 at an edge): every register cleared; dout_trans=0, dout_inert=0, drop=0, drop_cnt=0, all filter counters 0. rst overrides en and cnt_clr. Reset mid-pulse discards the pulse; nothing is counted.
- Transport path: per channel a DELAY-stage shift register; dout_trans[c] equals din[c] sampled DELAY edges earlier. Pulses of any width, including 1 cycle, are preserved exactly.
- Inertial path, per channel: state register q (drives dout_inert) and counter f (width clog2(FILT)+1).
  - din==q: f<=0. If f!=0 at that edge, the excursion was shorter than FILT, so drop[c]<=1.
  - din!=q and f==FILT-1: q<=din, f<=0 (change accepted).
  - din!=q otherwise: f<=f+1.
  - FILT=1: q follows din with 1-cycle latency; drop is never asserted.
- drop is registered and high for exactly one cycle per rejected excursion; otherwise 0.
- drop_cnt: each enabled edge adds popcount of the drop events detected at that edge; it saturates at 2^CNTW-1 and never wraps. cnt_clr=1 sets it to 0, and drops detected in that same cycle are not counted (their drop pulses still fire).
- en=0: shift registers, q, f and drop_cnt hold; drop<=0. Input activity while en=0 is ignored, not filtered.
- Channels are fully independent; simultaneous drops on several channels are all counted in the same cycle.

## Timing
- dout_trans latency: DELAY cycles, fixed.
- dout_inert latency: a level held for at least FILT consecutive sampled cycles appears at dout_inert after the FILT-th sampling edge, i.e. FILT cycles after din changes.
- Rejection: an excursion of 1..FILT-1 cycles never reaches dout_inert. drop pulses the cycle after din returns to q.
- drop_cnt updates one cycle after the drop is detected, the same edge that drives the drop pulse.
- No combinational paths from inputs to outputs; all outputs are registered.

## Test plan
- Reset: hold rst 3 cycles with din=2'b11 → all outputs 0. Release rst → dout_inert=2'b11 after 3 cycles and dout_trans=2'b11 after 4 cycles.
- Long pulse, CH=2, DELAY=4, FILT=3: din[0] high for 6 cycles → dout_trans[0] high for 6 cycles starting 4 cycles later; dout_inert[0] high for 6 cycles starting 3 cycles later; drop=0.
- Short pulses: din[0] high for 2 cycles, then din[1] low for 1 cycle from high → dout_trans shows both pulses. dout_inert is unchanged. drop[0] pulses, then drop[1] pulses, and drop_cnt=2.
- Simultaneous drops with clear: both channels 1-cycle glitches on the same cycle → drop=2'b11, drop_cnt+=2. Repeat with cnt_clr asserted in the detection cycle → drop=2'b11 and drop_cnt=0.
- Saturation with CNTW=2: 5 glitches → drop_cnt stops at 3.
- Enable and mid-operation reset: en=0 while din toggles → outputs hold and drop stays 0. Assert rst mid-way through a 2-cycle qualification → all outputs 0 next cycle and no drop counted.

Source files
------------

// File: rtl/glitch_delay_filter_if.sv
// glitch_delay_filter_if: enable, channel inputs and filtered outputs of the delay/filter block
interface glitch_delay_filter_if #(
    parameter int CH   = 2,
    parameter int CNTW = 8
);
    logic            en;
    logic [CH-1:0]   din;
    logic            cnt_clr;
    logic [CH-1:0]   dout_trans;
    logic [CH-1:0]   dout_inert;
    logic [CH-1:0]   drop;
    logic [CNTW-1:0] drop_cnt;
    modport master (output en, din, cnt_clr, input dout_trans, dout_inert, drop, drop_cnt);
    modport slave (input en, din, cnt_clr, output dout_trans, dout_inert, drop, drop_cnt);
endinterface

// File: rtl/glitch_delay_filter.sv
// glitch_delay_filter: per-channel transport delay plus inertial filter with rejected-pulse counting
module glitch_delay_filter #(
    parameter int CH    = 2,
    parameter int DELAY = 4,
    parameter int FILT  = 3,
    parameter int CNTW  = 8
) (
    input logic clk,
    input logic rst,
    glitch_delay_filter_if.slave bus
);
    localparam int FW = $clog2(FILT) + 1;
    localparam int SW = CNTW + $clog2(CH + 1) + 1;
    logic [CH-1:0]   sr [DELAY];
    logic [CH-1:0]   q;
    logic [CH-1:0]   drop;
    logic [CH-1:0]   hit;
    logic [FW-1:0]   f [CH];
    logic [CNTW-1:0] cnt;
    logic [SW-1:0]   sum;
    // a return to q with a non-zero counter is an excursion shorter than FILT
    always_comb begin
        hit = '0;
        sum = SW'(cnt);
        for (int c = 0; c < CH; c++) begin
            hit[c] = (bus.din[c] == q[c]) && (f[c] != '0);
            sum = sum + SW'(hit[c]);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) sr[i] <= '0;
            for (int c = 0; c < CH; c++) f[c] <= '0;
            q    <= '0;
            drop <= '0;
            cnt  <= '0;
        end else if (!bus.en) begin
            drop <= '0;
        end else begin
            sr[0] <= bus.din;
            for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
            for (int c = 0; c < CH; c++) begin
                if (bus.din[c] == q[c]) begin
                    f[c] <= '0;
                end else if (f[c] == FW'(FILT - 1)) begin
                    q[c] <= bus.din[c];
                    f[c] <= '0;
                end else begin
                    f[c] <= f[c] + FW'(1);
                end
            end
            drop <= hit;
            cnt  <= bus.cnt_clr ? '0 : (sum > SW'({CNTW{1'b1}})) ? '1 : sum[CNTW-1:0];
        end
    end
    assign bus.dout_trans = sr[DELAY-1];
    assign bus.dout_inert = q;
    assign bus.drop       = drop;
    assign bus.drop_cnt   = cnt;
endmodule

// File: tb/tb_glitch_delay_filter.sv
// tb_glitch_delay_filter: directed checks of delay, filtering, drop counting, enable and reset
module tb_glitch_delay_filter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [1:0] din = 2'b11;
    logic       clr = 1'b0;
    int         total = 0;
    int         bad = 0;
    glitch_delay_filter_if #(.CH(2), .CNTW(8)) b8 ();
    glitch_delay_filter_if #(.CH(2), .CNTW(2)) b2 ();
    assign b8.en = en;
    assign b8.din = din;
    assign b8.cnt_clr = clr;
    assign b2.en = en;
    assign b2.din = din;
    assign b2.cnt_clr = clr;
    glitch_delay_filter #(.CH(2), .DELAY(4), .FILT(3), .CNTW(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
    glitch_delay_filter #(.CH(2), .DELAY(4), .FILT(3), .CNTW(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic [1:0] d, input logic c);
        rst = r;
        en  = e;
        din = d;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string t, input logic [1:0] o, input logic [1:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
    endtask

    task automatic chk8(input string t, input logic [7:0] o, input logic [7:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", t, o, e);
        end
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b1, 2'b11, 1'b0);
        chk2("rst_trans", b8.dout_trans, 2'b00);
        chk2("rst_inert", b8.dout_inert, 2'b00);
        chk2("rst_drop", b8.drop, 2'b00);
        chk8("rst_cnt", b8.drop_cnt, 8'd0);
        chk2("rst_cnt2", b2.drop_cnt, 2'd0);
        step(1'b0, 1'b1, 2'b11, 1'b0);
        step(1'b0, 1'b1, 2'b11, 1'b0);
        chk2("rel_inert_e2", b8.dout_inert, 2'b00);
        step(1'b0, 1'b1, 2'b11, 1'b0);
        chk2("rel_inert_e3", b8.dout_inert, 2'b11);
        chk2("rel_trans_e3", b8.dout_trans, 2'b00);
        step(1'b0, 1'b1, 2'b11, 1'b0);
        chk2("rel_trans_e4", b8.dout_trans, 2'b11);
        chk2("rel_drop", b8.drop, 2'b00);
        repeat (6) step(1'b0, 1'b1, 2'b00, 1'b0);
        chk2("idle_inert", b8.dout_inert, 2'b00);
        chk2("idle_trans", b8.dout_trans, 2'b00);
        chk8("idle_cnt", b8.drop_cnt, 8'd0);
        // six-cycle pulse on channel 0
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, (i <= 6) ? 2'b01 : 2'b00, 1'b0);
            chk2($sformatf("long_trans_%0d", i), b8.dout_trans, (i >= 4 && i <= 9) ? 2'b01 : 2'b00);
            chk2($sformatf("long_inert_%0d", i), b8.dout_inert, (i >= 3 && i <= 8) ? 2'b01 : 2'b00);
            chk2($sformatf("long_drop_%0d", i), b8.drop, 2'b00);
        end
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        chk2("short0_drop", b8.drop, 2'b01);
        chk8("short0_cnt", b8.drop_cnt, 8'd1);
        chk2("short0_inert", b8.dout_inert, 2'b00);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("short0_drop_off", b8.drop, 2'b00);
        chk2("short0_trans_a", b8.dout_trans, 2'b01);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("short0_trans_b", b8.dout_trans, 2'b01);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("ch1_up_inert", b8.dout_inert, 2'b10);
        chk2("short0_trans_end", b8.dout_trans, 2'b00);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        chk2("short1_inert", b8.dout_inert, 2'b10);
        chk2("short1_nodrop", b8.drop, 2'b00);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("short1_drop", b8.drop, 2'b10);
        chk8("short1_cnt", b8.drop_cnt, 8'd2);
        chk2("short1_cnt2", b2.drop_cnt, 2'd2);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("short1_drop_off", b8.drop, 2'b00);
        chk2("short1_trans_pre", b8.dout_trans, 2'b10);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("short1_trans_gl", b8.dout_trans, 2'b00);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("short1_trans_post", b8.dout_trans, 2'b10);
        // both channels glitch together, then again with a clear in the detection cycle
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("dual_drop", b8.drop, 2'b11);
        chk8("dual_cnt", b8.drop_cnt, 8'd4);
        chk2("dual_cnt2_sat", b2.drop_cnt, 2'd3);
        chk2("dual_inert", b8.dout_inert, 2'b10);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("dual_drop_off", b8.drop, 2'b00);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b0, 1'b1, 2'b10, 1'b1);
        chk2("clr_drop", b8.drop, 2'b11);
        chk8("clr_cnt", b8.drop_cnt, 8'd0);
        chk2("clr_cnt2", b2.drop_cnt, 2'd0);
        step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("clr_drop_off", b8.drop, 2'b00);
        chk8("clr_cnt_hold", b8.drop_cnt, 8'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 2'b11, 1'b0);
            step(1'b0, 1'b1, 2'b10, 1'b0);
            chk2($sformatf("sat_drop_%0d", k), b8.drop, 2'b01);
            chk8($sformatf("sat_cnt_%0d", k), b8.drop_cnt, 8'(k));
            chk2($sformatf("sat_cnt2_%0d", k), b2.drop_cnt, 2'((k > 3) ? 3 : k));
        end
        repeat (4) step(1'b0, 1'b1, 2'b10, 1'b0);
        chk2("settle_trans", b8.dout_trans, 2'b10);
        // a pending change on channel 1 must survive a disabled stretch untouched
        step(1'b0, 1'b1, 2'b00, 1'b0);
        chk2("en_pend_inert", b8.dout_inert, 2'b10);
        step(1'b0, 1'b0, 2'b10, 1'b0);
        chk2("en_off_drop", b8.drop, 2'b00);
        chk2("en_off_inert", b8.dout_inert, 2'b10);
        chk2("en_off_trans", b8.dout_trans, 2'b10);
        step(1'b0, 1'b0, 2'b01, 1'b0);
        chk2("en_off_drop2", b8.drop, 2'b00);
        chk8("en_off_cnt", b8.drop_cnt, 8'd5);
        chk2("en_off_cnt2", b2.drop_cnt, 2'd3);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        chk2("en_on_inert", b8.dout_inert, 2'b10);
        chk2("en_on_drop", b8.drop, 2'b00);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        chk2("en_accept_inert", b8.dout_inert, 2'b00);
        chk2("en_accept_drop", b8.drop, 2'b00);
        step(1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b1, 1'b1, 2'b01, 1'b0);
        chk2("mid_rst_trans", b8.dout_trans, 2'b00);
        chk2("mid_rst_inert", b8.dout_inert, 2'b00);
        chk2("mid_rst_drop", b8.drop, 2'b00);
        chk8("mid_rst_cnt", b8.drop_cnt, 8'd0);
        chk2("mid_rst_cnt2", b2.drop_cnt, 2'd0);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        chk2("post_rst_drop", b8.drop, 2'b00);
        chk8("post_rst_cnt", b8.drop_cnt, 8'd0);
        chk2("post_rst_inert", b8.dout_inert, 2'b00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
